// File: rtl/mult8_sweep_checker_if.sv
// mult8_sweep_checker_if: operand/product bus between the sweep checker and the multiplier under test
interface mult8_sweep_checker_if;
  logic [7:0]  a_o;
  logic [7:0]  b_o;
  logic [15:0] p_i;
  modport master (output a_o, b_o, input p_i);
  modport slave (input a_o, b_o, output p_i);
endinterface

// File: rtl/mult8_sweep_checker.sv
// mult8_sweep_checker: exhaustive 8x8 multiplier sweep checker; MULT_CHK_STOP_ON_ERR_EN stops at first mismatch
module mult8_sweep_checker #(
  parameter int LAT   = 0,
  parameter int ERR_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  mult8_sweep_checker_if.master bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [7:0]       ferr_a_o,
  output logic [7:0]       ferr_b_o,
  output logic [15:0]      ferr_p_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [15:0] idx;
  logic [2:0] dcnt;
  logic run, last, cv, mis, stop, fin;
  logic [7:0] ca, cb;
  logic [ERR_W-1:0] err_inc;
  assign {bus.a_o, bus.b_o} = idx;
  assign run = state == RUN;
  assign last = idx == 16'hFFFF;
  assign mis = cv && (bus.p_i != 16'(ca) * 16'(cb));
  assign err_inc = err_cnt_o + ERR_W'(mis && !(&err_cnt_o));
`ifdef MULT_CHK_STOP_ON_ERR_EN
  assign stop = mis;
`else
  assign stop = 1'b0;
`endif
  assign fin = stop || (run && last && LAT == 0) || (state == DRAIN && dcnt == 3'd0);
  generate
    if (LAT == 0) begin : g_nodly
      assign {cv, ca, cb} = {run, idx};
    end else begin : g_dly
      logic [16:0] dl [LAT];
      // shift {valid,a,b} alongside the multiplier pipeline; a stop flushes in-flight vectors
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int k = 0; k < LAT; k++) dl[k] <= '0;
        end else begin
          dl[0] <= {run, idx};
          for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
          if (stop) for (int k = 0; k < LAT; k++) dl[k][16] <= 1'b0;
        end
      assign {cv, ca, cb} = dl[LAT-1];
    end
  endgenerate
  // sweep sequencing, mismatch counting and first-failure capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      dcnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
      err_cnt_o <= '0;
      {ferr_a_o, ferr_b_o, ferr_p_o} <= '0;
    end else if ((state == IDLE || state == DONE) && start_i) begin
      state <= RUN;
      idx <= '0;
      busy_o <= 1'b1;
      done_o <= 1'b0;
      pass_o <= 1'b0;
      err_cnt_o <= '0;
      {ferr_a_o, ferr_b_o, ferr_p_o} <= '0;
    end else begin
      if (mis) begin
        err_cnt_o <= err_inc;
        if (err_cnt_o == '0) {ferr_a_o, ferr_b_o, ferr_p_o} <= {ca, cb, bus.p_i};
      end
      if (fin) begin
        state <= DONE;
        busy_o <= 1'b0;
        done_o <= 1'b1;
        pass_o <= err_inc == '0;
      end else if (run && last) begin
        state <= DRAIN;
        dcnt <= 3'(LAT - 1);
      end else if (run) idx <= idx + 16'd1;
      else if (state == DRAIN) dcnt <= dcnt - 3'd1;
    end
endmodule

// File: tb/tb_mult8_sweep_checker.sv
// tb_mult8_sweep_checker: parallel sweeps against ideal, faulty and pipelined multiplier models
module tb_mult8_sweep_checker;
  localparam int N = 6;
  localparam int LATS [N] = '{0, 0, 0, 2, 1, 0};
  typedef struct {int cyc; int err; logic [7:0] fa; logic [7:0] fb; logic [15:0] fp; logic pass;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rst5_n = 1'b0, start = 1'b0, start5 = 1'b0;
  logic busy [N], done [N], pass [N], prev [N];
  logic [16:0] err [N];
  logic [7:0] fa [N], fb [N], ao [N], bo [N];
  logic [15:0] fp [N];
  exp_t sb [N][$];
  exp_t e;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  generate
    for (genvar i = 0; i < N; i++) begin : g
      mult8_sweep_checker_if bus();
      logic rn, st;
      logic [15:0] prod, f, p1, p2;
      assign rn = i == 5 ? rst5_n : rst_n;
      assign st = i == 5 ? start5 : start;
      assign prod = 16'(bus.a_o) * 16'(bus.b_o);
      assign f = (i == 1 && bus.a_o == 8'd3 && bus.b_o == 8'd5) ? prod ^ 16'd1 :
                 (i == 2 && bus.a_o == 8'd255) ? 16'd0 : prod;
      // two-stage registered multiplier model for the pipelined instances
      always @(posedge clk or negedge rn)
        if (!rn) begin
          p1 <= '0;
          p2 <= '0;
        end else begin
          p1 <= f;
          p2 <= p1;
        end
      assign bus.p_i = LATS[i] > 0 ? p2 : f;
      assign ao[i] = bus.a_o;
      assign bo[i] = bus.b_o;
      mult8_sweep_checker #(.LAT(LATS[i]), .ERR_W(17)) dut (
        .clk(clk), .rst_n(rn), .start_i(st), .bus(bus.master),
        .busy_o(busy[i]), .done_o(done[i]), .pass_o(pass[i]), .err_cnt_o(err[i]),
        .ferr_a_o(fa[i]), .ferr_b_o(fb[i]), .ferr_p_o(fp[i])
      );
    end
  endgenerate
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic push(input int i, input int cyc, input int er, input int a, input int b, input int p, input int ps);
    exp_t x;
    x.cyc = cyc; x.err = er; x.fa = 8'(a); x.fb = 8'(b); x.fp = 16'(p); x.pass = ps[0];
    sb[i].push_back(x);
  endtask
  task automatic zeros(input int i, input string tag);
    chk({tag, "_busy"}, 32'(busy[i]), 0);
    chk({tag, "_done"}, 32'(done[i]), 0);
    chk({tag, "_pass"}, 32'(pass[i]), 0);
    chk({tag, "_err"}, 32'(err[i]), 0);
    chk({tag, "_ferr"}, {fa[i], fb[i], fp[i]}, 0);
    chk({tag, "_ab"}, {16'd0, ao[i], bo[i]}, 0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) zeros(i, $sformatf("rst%0d", i));
    rst_n = 1'b1;
    rst5_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) prev[i] = done[i];
    push(0, 65537, 0, 0, 0, 0, 1);
`ifdef MULT_CHK_STOP_ON_ERR_EN
    push(1, 16'h0307, 1, 3, 5, 14, 0);
    push(2, 16'hFF03, 1, 255, 1, 0, 0);
    push(4, 16'h0104, 1, 1, 1, 0, 0);
`else
    push(1, 65537, 1, 3, 5, 14, 0);
    push(2, 65537, 255, 255, 1, 0, 0);
    push(4, 65538, 65279, 1, 1, 0, 0);
`endif
    push(3, 65539, 0, 0, 0, 0, 1);
    start = 1'b1;
    start5 = 1'b1;
    n = 0;
    while (n < 70000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        start5 = 1'b0;
      end
      if (n == 1 || n == 2 || n == 257 || n == 65536) begin
        chk($sformatf("idx@%0d", n), {16'd0, ao[0], bo[0]}, n - 1);
        chk($sformatf("busy@%0d", n), 32'(busy[0]), 1);
      end
      if (n == 65537) begin
        chk("drain_busy", 32'(busy[3]), 1);
        chk("drain_ab", {16'd0, ao[3], bo[3]}, 32'hFFFF);
      end
      if (n == 1000) begin
        chk("pre_rst_idx", {16'd0, ao[5], bo[5]}, 999);
        rst5_n = 1'b0;
        #1 zeros(5, "midrst");
        rst5_n = 1'b1;
      end
      if (n == 1002) begin
        start5 = 1'b1;
        push(5, 1002 + 65537, 0, 0, 0, 0, 1);
      end
      if (n == 1003) start5 = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (done[i] && !prev[i]) begin
          if (sb[i].size() == 0) chk($sformatf("spurious_done%0d", i), 1, 0);
          else begin
            e = sb[i].pop_front();
            chk($sformatf("cyc%0d", i), n, e.cyc);
            chk($sformatf("err%0d", i), 32'(err[i]), e.err);
            chk($sformatf("ferr_a%0d", i), 32'(fa[i]), 32'(e.fa));
            chk($sformatf("ferr_b%0d", i), 32'(fb[i]), 32'(e.fb));
            chk($sformatf("ferr_p%0d", i), 32'(fp[i]), 32'(e.fp));
            chk($sformatf("pass%0d", i), 32'(pass[i]), 32'(e.pass));
            chk($sformatf("busy_end%0d", i), 32'(busy[i]), 0);
          end
        end
        prev[i] = done[i];
      end
      if (n > 1002 && sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size() + sb[5].size() == 0) break;
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("pending%0d", i), sb[i].size(), 0);
      chk($sformatf("held%0d", i), 32'(done[i]), 1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("re_done%0d", i), 32'(done[i]), 0);
      chk($sformatf("re_pass%0d", i), 32'(pass[i]), 0);
      chk($sformatf("re_busy%0d", i), 32'(busy[i]), 1);
      chk($sformatf("re_err%0d", i), 32'(err[i]), 0);
      chk($sformatf("re_ferr%0d", i), {fa[i], fb[i], fp[i]}, 0);
      chk($sformatf("re_ab%0d", i), {16'd0, ao[i], bo[i]}, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
